// File: rtl/game_state_ctrl.sv
// game_state_ctrl: per-frame game-flow controller for the invaders top level.
// Captures laser/alien and bomb/cannon collisions during the scan and owns alive matrix, score, lives and wave.
`default_nettype none

module game_state_ctrl #(
  parameter int NUM_ROWS          = 5,
  parameter int NUM_COLUMNS       = 8,
  parameter int INITIAL_LIVES     = 3,
  parameter int LIVES_WIDTH       = 2,
  parameter int SCORE_WIDTH       = 8,
  parameter int POINTS_BASE       = 1,
  parameter int POINTS_STEP       = 1,
  parameter int WAVE_WIDTH        = 4,
  parameter int HIT_HOLD_FRAMES   = 60,
  parameter int CLEAR_HOLD_FRAMES = 60
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  vsync,
  input  logic                                  display_on,
  input  logic                                  start,
  input  logic                                  laser_gfx,
  input  logic                                  alien_pixel,
  input  logic [$clog2(NUM_ROWS)-1:0]           alien_row,
  input  logic [$clog2(NUM_COLUMNS)-1:0]        alien_col,
  input  logic                                  cannon_gfx,
  input  logic                                  bomb_gfx,
  input  logic                                  invaded,
  output logic [NUM_ROWS*NUM_COLUMNS-1:0]       alive_matrix,
  output logic                                  hit_alien,
  output logic [SCORE_WIDTH-1:0]                score,
  output logic [LIVES_WIDTH-1:0]                lives,
  output logic [WAVE_WIDTH-1:0]                 wave,
  output logic [2:0]                            state,
  output logic                                  freeze
);

  localparam int NUM_ALIENS = NUM_ROWS * NUM_COLUMNS;
  localparam int ROW_W      = $clog2(NUM_ROWS);
  localparam int IDX_W      = $clog2(NUM_ALIENS);
  localparam int HOLD_MAX   = (HIT_HOLD_FRAMES > CLEAR_HOLD_FRAMES) ? HIT_HOLD_FRAMES : CLEAR_HOLD_FRAMES;
  localparam int HOLD_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = '1;
  localparam logic [WAVE_WIDTH-1:0]  WAVE_MAX   = '1;
  localparam logic [NUM_ALIENS-1:0]  ALL_ALIVE  = '1;
  localparam logic [NUM_ALIENS-1:0]  ONE_ALIEN  = NUM_ALIENS'(1);
  localparam logic [HOLD_W-1:0]      HIT_LAST   = HOLD_W'(HIT_HOLD_FRAMES - 1);
  localparam logic [HOLD_W-1:0]      CLEAR_LAST = HOLD_W'(CLEAR_HOLD_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PLAYING    = 3'd1,
    S_PLAYER_HIT = 3'd2,
    S_WAVE_CLEAR = 3'd3,
    S_GAME_OVER  = 3'd4
  } state_t;

  state_t             st;
  logic               vsync_q;
  logic               start_q;
  logic               kill_flag;
  logic [IDX_W-1:0]   kill_idx;
  logic [ROW_W-1:0]   kill_row;
  logic               player_hit_flag;
  logic [HOLD_W-1:0]  hold_cnt;

  logic                   tick;
  logic                   start_edge;
  logic [IDX_W-1:0]       scan_idx;
  logic                   scan_in_range;
  logic                   capture_ok;
  logic                   kill_now;
  logic                   bomb_now;
  logic [NUM_ALIENS-1:0]  alive_after;
  logic [SCORE_WIDTH:0]   score_sum;
  logic [SCORE_WIDTH-1:0] score_after;
  logic [LIVES_WIDTH-1:0] lives_dec;

  function automatic logic [SCORE_WIDTH:0] row_points(input logic [ROW_W-1:0] r);
    int p;
    p = POINTS_BASE + (NUM_ROWS - 1 - int'(r)) * POINTS_STEP;
    return (SCORE_WIDTH+1)'(p);
  endfunction

  assign tick          = vsync & ~vsync_q;
  assign start_edge    = start & ~start_q;
  assign scan_idx      = IDX_W'(int'(alien_row) * NUM_COLUMNS + int'(alien_col));
  assign scan_in_range = (int'(alien_row) < NUM_ROWS) && (int'(alien_col) < NUM_COLUMNS);
  assign capture_ok    = (st == S_PLAYING) && display_on;
  assign kill_now      = capture_ok && laser_gfx && alien_pixel && scan_in_range && alive_matrix[scan_idx];
  assign bomb_now      = capture_ok && bomb_gfx && cannon_gfx;

  assign alive_after = kill_flag ? (alive_matrix & ~(ONE_ALIEN << kill_idx)) : alive_matrix;
  assign score_sum   = {1'b0, score} + row_points(kill_row);
  assign score_after = !kill_flag ? score : (score_sum[SCORE_WIDTH] ? SCORE_MAX : score_sum[SCORE_WIDTH-1:0]);
  assign lives_dec   = lives - 1'b1;

  assign state  = st;
  assign freeze = (st != S_PLAYING);

  always_ff @(posedge clk) begin
    if (reset) begin
      st              <= S_IDLE;
      vsync_q         <= 1'b0;
      start_q         <= 1'b0;
      kill_flag       <= 1'b0;
      kill_idx        <= '0;
      kill_row        <= '0;
      player_hit_flag <= 1'b0;
      hold_cnt        <= '0;
      alive_matrix    <= ALL_ALIVE;
      hit_alien       <= 1'b0;
      score           <= '0;
      lives           <= LIVES_WIDTH'(INITIAL_LIVES);
      wave            <= '0;
    end else begin
      vsync_q <= vsync;
      start_q <= start;

      // A collision seen on the tick clk itself opens the next frame's latches.
      if (tick) begin
        kill_flag       <= kill_now;
        kill_idx        <= scan_idx;
        kill_row        <= alien_row;
        player_hit_flag <= bomb_now;
        hit_alien       <= (st == S_PLAYING) && kill_flag;
      end else begin
        if (kill_now && !kill_flag) begin
          kill_flag <= 1'b1;
          kill_idx  <= scan_idx;
          kill_row  <= alien_row;
        end
        if (bomb_now) begin
          player_hit_flag <= 1'b1;
        end
      end

      case (st)
        S_IDLE: begin
          if (start_edge) begin
            st <= S_PLAYING;
          end
        end
        S_PLAYING: begin
          if (tick) begin
            alive_matrix <= alive_after;
            score        <= score_after;
            if (invaded) begin
              lives <= '0;
              st    <= S_GAME_OVER;
            end else if (player_hit_flag) begin
              lives    <= lives_dec;
              hold_cnt <= '0;
              st       <= (lives_dec == '0) ? S_GAME_OVER : S_PLAYER_HIT;
            end else if (alive_after == '0) begin
              hold_cnt <= '0;
              st       <= S_WAVE_CLEAR;
            end
          end
        end
        S_PLAYER_HIT: begin
          if (tick) begin
            if (hold_cnt == HIT_LAST) begin
              hold_cnt <= '0;
              st       <= (alive_matrix == '0) ? S_WAVE_CLEAR : S_PLAYING;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        S_WAVE_CLEAR: begin
          if (tick) begin
            if (hold_cnt == CLEAR_LAST) begin
              hold_cnt     <= '0;
              alive_matrix <= ALL_ALIVE;
              wave         <= (wave == WAVE_MAX) ? wave : wave + 1'b1;
              st           <= S_PLAYING;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        S_GAME_OVER: begin
          if (start_edge) begin
            alive_matrix    <= ALL_ALIVE;
            score           <= '0;
            lives           <= LIVES_WIDTH'(INITIAL_LIVES);
            wave            <= '0;
            hit_alien       <= 1'b0;
            kill_flag       <= 1'b0;
            player_hit_flag <= 1'b0;
            hold_cnt        <= '0;
            st              <= S_PLAYING;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Parametrised game-flow controller for the invaders top level.
- Replaces the hardwired lives constant, the undriven score and the tied-off hit_alien with a real controller.
- Detects laser/alien and bomb/cannon pixel collisions during the raster scan and owns the alien alive matrix, score, lives and wave counter.
- Sequences the game through attract, play, player-hit, wave-clear and game-over states, updating once per frame.

Parameters:
- NUM_ROWS, 5, alien formation rows.
- NUM_COLUMNS, 8, alien formation columns.
- INITIAL_LIVES, 3, lives loaded at game start.
- LIVES_WIDTH, 2, width of the lives output.
- SCORE_WIDTH, 8, width of the score output; score saturates.
- POINTS_BASE, 1, points for the bottom row (row NUM_ROWS-1).
- POINTS_STEP, 1, extra points per row moving upward; row r is worth POINTS_BASE+(NUM_ROWS-1-r)*POINTS_STEP.
- WAVE_WIDTH, 4, width of the wave counter; saturates.
- HIT_HOLD_FRAMES, 60, frames spent frozen after the player is hit.
- CLEAR_HOLD_FRAMES, 60, frames spent frozen after a wave is cleared.

Ports:
- clk  in  1  pixel clock (25 MHz).
- reset  in  1  synchronous, active-high reset.
- vsync  in  1  raster vsync; its rising edge is the frame tick.
- display_on  in  1  visible-area qualifier.
- start  in  1  start button, level; acted on at its rising edge.
- laser_gfx  in  1  laser pixel active.
- alien_pixel  in  1  alien pixel active.
- alien_row  in  $clog2(NUM_ROWS)  row of the alien under the scan.
- alien_col  in  $clog2(NUM_COLUMNS)  column of the alien under the scan.
- cannon_gfx  in  1  cannon pixel active.
- bomb_gfx  in  1  alien bomb pixel active.
- invaded  in  1  formation has reached the cannon line.
- alive_matrix  out  NUM_ROWS*NUM_COLUMNS  alive bits; bit index = row*NUM_COLUMNS+col.
- hit_alien  out  1  laser consumed; held for one frame.
- score  out  SCORE_WIDTH  current score.
- lives  out  LIVES_WIDTH  remaining lives.
- wave  out  WAVE_WIDTH  waves cleared.
- state  out  3  IDLE=0, PLAYING=1, PLAYER_HIT=2, WAVE_CLEAR=3, GAME_OVER=4.
- freeze  out  1  high whenever state != PLAYING.

Behaviour:
- Reset values:
  - state IDLE, alive_matrix all ones, score 0, lives INITIAL_LIVES, wave 0.
  - hit_alien 0, freeze 1, hold counter 0, collision latches clear.
- Frame tick: vsync is registered on clk; tick = vsync & ~vsync_q, a one-clk pulse. start is edge-detected the same way.
- Collision capture, active only when state==PLAYING and display_on:
  - The first clk with laser_gfx & alien_pixel & alive[alien_row][alien_col] latches the row/col and sets a kill flag.
  - Later overlaps in the same frame are ignored, so the first hit in scan order wins.
  - Overlaps on a dead alien are ignored.
  - bomb_gfx & cannon_gfx sets a player-hit flag.
- All latches are applied and cleared on the tick clk. A collision on the tick clk itself belongs to the next frame.
- Kill application, on the tick:
  - Clear the alive bit.
  - Add the row points to score, saturating at 2^SCORE_WIDTH-1.
  - hit_alien=1 until the next tick. With no kill in the frame, hit_alien=0 at that tick.
- IDLE:
  - Outputs hold their game-start values.
  - A start edge moves to PLAYING.
- PLAYING, evaluated on the tick in this priority order:
  - invaded: lives <= 0, go to GAME_OVER.
  - player-hit flag: lives decrement. If the result is 0, go to GAME_OVER; otherwise go to PLAYER_HIT with the hold counter at 0.
  - kill leaves alive all zero: go to WAVE_CLEAR.
  - Otherwise stay in PLAYING.
  - A kill and a player hit in the same frame: both are applied (score, alive bit and life all update). PLAYER_HIT or GAME_OVER wins over WAVE_CLEAR. If alive is all zero on return from PLAYER_HIT, go to WAVE_CLEAR instead of PLAYING.
- PLAYER_HIT:
  - The hold counter increments on each tick.
  - When the counter reaches HIT_HOLD_FRAMES-1, leave on that tick.
- WAVE_CLEAR:
  - Holds for CLEAR_HOLD_FRAMES ticks.
  - On exit: alive_matrix resets to all ones, wave increments (saturating), go to PLAYING.
  - Lives and score are kept.
- GAME_OVER:
  - Score, wave and lives are frozen.
  - A start edge reloads alive to all ones, score 0, lives INITIAL_LIVES, wave 0, and goes to PLAYING.
- start edges are ignored in every state other than IDLE and GAME_OVER.
- Reset asserted mid-game returns all outputs to their reset values on the next clk.

Test Plan:
- Reset, then a start pulse → state 1 on the next clk, freeze 0, alive 0xFF_FFFF_FFFF (40 bits), lives 3, score 0.
- Inject laser_gfx & alien_pixel at row 0, col 2 during the active area, then a vsync edge → bit 2 cleared, score 5 (POINTS 1+4*1), hit_alien 1 for exactly one frame.
- Two overlaps in the same frame (row 4 col 7, then row 0 col 0) → only bit 39 is cleared, score +1.
- Kill all 40 aliens → WAVE_CLEAR; after 60 ticks alive is all ones, wave 1, state PLAYING, score 5*8+4*8+3*8+2*8+1*8=120.
- Three bomb/cannon hits → lives 2 and 1, each followed by a 60-tick PLAYER_HIT; the third hit gives lives 0 and GAME_OVER. A start edge then restores lives 3, score 0 and PLAYING.
- A kill and a player hit in the same frame → score adds, lives decrement, state PLAYER_HIT. Separately, score at 254 plus a row-0 kill → saturates at 255.
